uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between three byte sources: command-response bytes from the main FSM, end-of-data marker bytes, and the ADC sample FIFO stream.
- Replaces the OR-merge of general data and strobes in front of the transmitter.
- Buffers single-byte strobed sources, sequences FIFO reads with a fixed read latency, and bounds ADC bursts so command responses are never starved.

---
 rtl/uart_tx_arbiter_if.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of source, FIFO and UART-side signals for the UART transmit arbiter.
// Defining TX_ARB_STATS_EN adds the per-source byte counters to the bundle.
interface uart_tx_arbiter_if;
  logic [7:0]  cmd_data;
  logic        cmd_wr;
  logic [7:0]  eod_data;
  logic        eod_wr;
  logic        fifo_not_empty;
  logic        fifo_rd;
  logic [7:0]  fifo_data;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant;
  logic        overflow;
`ifdef TX_ARB_STATS_EN
  logic [15:0] cmd_count;
  logic [15:0] eod_count;
  logic [15:0] adc_count;
`endif

  // Driver side: the sources, the FIFO and the UART.
  modport master (
    output cmd_data, cmd_wr, eod_data, eod_wr, fifo_not_empty, fifo_data, tx_busy,
    input  fifo_rd, tx_data, tx_start, grant, overflow
`ifdef TX_ARB_STATS_EN
    , input cmd_count, eod_count, adc_count
`endif
  );

  // Arbiter side.
  modport slave (
    input  cmd_data, cmd_wr, eod_data, eod_wr, fifo_not_empty, fifo_data, tx_busy,
    output fifo_rd, tx_data, tx_start, grant, overflow
`ifdef TX_ARB_STATS_EN
    , output cmd_count, eod_count, adc_count
`endif
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between the command-response source, the
// end-of-data marker source and the ADC sample FIFO. Strobed sources are held
// in one-byte registers; ADC bursts are capped at BURST_MAX bytes per grant.
// Optional macro TX_ARB_STATS_EN adds saturating per-source byte counters.
module uart_tx_arbiter #(
  parameter int unsigned BURST_MAX   = 64,
  parameter int unsigned FIFO_RD_LAT = 1
) (
  input logic              clk,
  input logic              Reset_n,
  uart_tx_arbiter_if.slave bus
);

  localparam logic [7:0] BurstMax = 8'(BURST_MAX);
  localparam logic [1:0] LatLast  = 2'(FIFO_RD_LAT - 1);

  localparam logic [1:0] GrNone = 2'd0;
  localparam logic [1:0] GrCmd  = 2'd1;
  localparam logic [1:0] GrEod  = 2'd2;
  localparam logic [1:0] GrAdc  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWaitHi,
    StWaitLo,
    StAdcRd,
    StAdcWait
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q;
  logic [7:0]  tx_data_q;
  logic [7:0]  burst_q;
  logic [1:0]  lat_q;
  logic [7:0]  cmd_byte_q, eod_byte_q;
  logic        cmd_pend_q, eod_pend_q;
  logic        overflow_q;

  logic        tx_start;
  logic        fifo_rd;
  logic        adc_more;
  logic        cmd_clr, eod_clr;

  // Keep the ADC grant only while the burst budget and the FIFO both allow it.
  assign adc_more = (grant_q == GrAdc) && (burst_q < BurstMax) && bus.fifo_not_empty;

  // A held byte is released in the same cycle its tx_start goes out.
  assign cmd_clr = tx_start && (grant_q == GrCmd);
  assign eod_clr = tx_start && (grant_q == GrEod);

  // State register.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; eod can only win in IDLE, so it never interrupts a burst.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_pend_q || eod_pend_q) begin
          state_d = StSend;
        end else if (bus.fifo_not_empty) begin
          state_d = StAdcRd;
        end
      end
      StSend: begin
        if (!bus.tx_busy) state_d = StWaitHi;
      end
      StWaitHi: begin
        if (bus.tx_busy) state_d = StWaitLo;
      end
      StWaitLo: begin
        if (!bus.tx_busy) state_d = adc_more ? StAdcRd : StIdle;
      end
      StAdcRd: begin
        if (!bus.fifo_not_empty) begin
          state_d = StIdle;
        end else if (!bus.tx_busy) begin
          state_d = StAdcWait;
        end
      end
      StAdcWait: begin
        if (lat_q == LatLast) state_d = StSend;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output strobes, guarded so neither can fire while the UART is busy.
  always_comb begin
    tx_start = 1'b0;
    fifo_rd  = 1'b0;
    if (state_q == StSend) tx_start = !bus.tx_busy;
    if (state_q == StAdcRd) fifo_rd = bus.fifo_not_empty && !bus.tx_busy;
  end

  // Grant, outgoing byte, burst count and FIFO latency count.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      grant_q   <= GrNone;
      tx_data_q <= 8'h00;
      burst_q   <= 8'h00;
      lat_q     <= 2'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_pend_q) begin
            grant_q   <= GrCmd;
            tx_data_q <= cmd_byte_q;
          end else if (eod_pend_q) begin
            grant_q   <= GrEod;
            tx_data_q <= eod_byte_q;
          end else if (bus.fifo_not_empty) begin
            grant_q <= GrAdc;
          end
        end
        StAdcRd: begin
          lat_q <= 2'd0;
          if (fifo_rd) burst_q <= burst_q + 8'd1;
          if (state_d == StIdle) begin
            grant_q <= GrNone;
            burst_q <= 8'h00;
          end
        end
        StAdcWait: begin
          lat_q <= lat_q + 2'd1;
          if (lat_q == LatLast) tx_data_q <= bus.fifo_data;
        end
        StWaitLo: begin
          if (state_d == StIdle) begin
            grant_q <= GrNone;
            burst_q <= 8'h00;
          end
        end
        default: ;
      endcase
    end
  end

  // Holding registers and the sticky overflow flag.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cmd_byte_q <= 8'h00;
      cmd_pend_q <= 1'b0;
      eod_byte_q <= 8'h00;
      eod_pend_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (bus.cmd_wr) begin
        if (!cmd_pend_q || cmd_clr) begin
          cmd_byte_q <= bus.cmd_data;
          cmd_pend_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (cmd_clr) begin
        cmd_pend_q <= 1'b0;
      end

      if (bus.eod_wr) begin
        if (!eod_pend_q || eod_clr) begin
          eod_byte_q <= bus.eod_data;
          eod_pend_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (eod_clr) begin
        eod_pend_q <= 1'b0;
      end
    end
  end

  assign bus.tx_start = tx_start;
  assign bus.fifo_rd  = fifo_rd;
  assign bus.tx_data  = tx_data_q;
  assign bus.grant    = grant_q;
  assign bus.overflow = overflow_q;

`ifdef TX_ARB_STATS_EN
  logic [15:0] cmd_cnt_q, eod_cnt_q, adc_cnt_q;

  // Saturating per-source counts of bytes handed to the UART.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cmd_cnt_q <= 16'h0000;
      eod_cnt_q <= 16'h0000;
      adc_cnt_q <= 16'h0000;
    end else if (tx_start) begin
      unique case (grant_q)
        GrCmd:   if (cmd_cnt_q != 16'hFFFF) cmd_cnt_q <= cmd_cnt_q + 16'd1;
        GrEod:   if (eod_cnt_q != 16'hFFFF) eod_cnt_q <= eod_cnt_q + 16'd1;
        GrAdc:   if (adc_cnt_q != 16'hFFFF) adc_cnt_q <= adc_cnt_q + 16'd1;
        default: ;
      endcase
    end
  end

  assign bus.cmd_count = cmd_cnt_q;
  assign bus.eod_count = eod_cnt_q;
  assign bus.adc_count = adc_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes the expected
// {grant, byte} of each transmission; a negedge monitor pops on every tx_start.
module tb_uart_tx_arbiter;
  localparam int unsigned BurstMax = 4;
  localparam int unsigned RdLat    = 2;
  localparam int unsigned BusyLen  = 10;
  localparam int          Bound    = 3000;

  logic clk     = 1'b0;
  logic Reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(
    .BURST_MAX  (BurstMax),
    .FIFO_RD_LAT(RdLat)
  ) dut (
    .clk    (clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  int         n_start     = 0;
  int         n_rd        = 0;
  int         last_start_cyc = -1;
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;

  logic [7:0] fifo_mem [0:31];
  int         fifo_wp = 0;
  int         fifo_rp = 0;
  int         rd_idx  = 0;
  logic       rd_pipe = 1'b0;
  logic [7:0] fifo_data_r = 8'hA5;
  logic [3:0] busy_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // UART model: busy rises the clock after tx_start and lasts BusyLen clocks.
  always @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) busy_cnt <= 4'd0;
    else if (bus.tx_start) busy_cnt <= 4'(BusyLen);
    else if (busy_cnt != 4'd0) busy_cnt <= busy_cnt - 4'd1;
  end
  assign bus.tx_busy = (busy_cnt != 4'd0);

  // FIFO model: data is valid only in the cycle RdLat (=2) clocks after fifo_rd.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pipe <= bus.fifo_rd;
    if (bus.fifo_rd) begin
      rd_idx  <= fifo_rp;
      fifo_rp <= fifo_rp + 1;
    end
    fifo_data_r <= rd_pipe ? fifo_mem[rd_idx] : 8'hA5;
  end
  assign bus.fifo_data      = fifo_data_r;
  assign bus.fifo_not_empty = (fifo_wp != fifo_rp);

  // Monitor.
  always @(negedge clk) begin
    if (Reset_n) begin
      if (bus.tx_start) begin
        n_start++;
        last_start_cyc = cyc;
        check("start_while_busy", 32'(bus.tx_busy), 32'd0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_tx: got %0h, expected no transmission", bus.tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("tx_data", 32'(bus.tx_data), 32'(mon_e[7:0]));
          check("tx_grant", 32'(bus.grant), 32'(mon_e[9:8]));
        end
      end
      if (bus.fifo_rd) begin
        n_rd++;
        check("rd_while_busy", 32'(bus.tx_busy), 32'd0);
        check("rd_when_empty", 32'(bus.fifo_not_empty), 32'd1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic strobe(input logic c, input logic [7:0] cd, input logic e, input logic [7:0] ed);
    bus.cmd_wr   = c;
    bus.cmd_data = cd;
    bus.eod_wr   = e;
    bus.eod_data = ed;
    tick(1);
    bus.cmd_wr = 1'b0;
    bus.eod_wr = 1'b0;
  endtask

  task automatic push(input logic [1:0] g, input logic [7:0] b);
    exp_q.push_back({g, b});
  endtask

  task automatic preload(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) fifo_mem[fifo_wp + i] = first + 8'(i);
    fifo_wp = fifo_wp + n;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && bus.grant == 2'd0 && !bus.tx_busy) && n < Bound) begin
      tick(1);
      n++;
    end
    check({name, "_drain_timeout"}, 32'(n < Bound), 32'd1);
  endtask

  task automatic wait_starts(input int target);
    int n = 0;
    while (n_start < target && n < Bound) begin
      tick(1);
      n++;
    end
    check("start_wait_timeout", 32'(n < Bound), 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_fifo_rd"},  32'(bus.fifo_rd),  32'd0);
    check({name, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    check({name, "_tx_data"},  32'(bus.tx_data),  32'd0);
    check({name, "_grant"},    32'(bus.grant),    32'd0);
    check({name, "_overflow"}, 32'(bus.overflow), 32'd0);
  endtask

  initial begin
    int s;
    int base;
    bus.cmd_wr   = 1'b0;
    bus.cmd_data = 8'h00;
    bus.eod_wr   = 1'b0;
    bus.eod_data = 8'h00;

    tick(3);
    check_reset_outputs("reset");
    Reset_n = 1'b1;
    tick(2);

    // Single command byte: tx_start two cycles after the strobe.
    push(2'd1, 8'h41);
    s = cyc;
    strobe(1'b1, 8'h41, 1'b0, 8'h00);
    wait_drain("single");
    check("cmd_latency", 32'(last_start_cyc), 32'(s + 2));
    check("single_grant_idle", 32'(bus.grant), 32'd0);
    check("single_overflow", 32'(bus.overflow), 32'd0);

    // Simultaneous strobes: cmd first, then eod, no overflow.
    push(2'd1, 8'h11);
    push(2'd2, 8'hEE);
    strobe(1'b1, 8'h11, 1'b1, 8'hEE);
    wait_drain("simul");
    check("simul_overflow", 32'(bus.overflow), 32'd0);

    // Overflow: second strobe while the first byte is still held.
    push(2'd1, 8'h41);
    strobe(1'b1, 8'h41, 1'b0, 8'h00);
    strobe(1'b1, 8'h42, 1'b0, 8'h00);
    wait_drain("ovf");
    check("ovf_set", 32'(bus.overflow), 32'd1);

    // Burst limit of 4 with a command arriving during the second ADC byte.
    for (int i = 0; i < 4; i++) push(2'd3, 8'(i));
    push(2'd1, 8'h55);
    for (int i = 4; i < 10; i++) push(2'd3, 8'(i));
    base = n_start;
    s    = n_rd;
    preload(8'h00, 10);
    wait_starts(base + 2);
    strobe(1'b1, 8'h55, 1'b0, 8'h00);
    wait_drain("burst");
    check("burst_rd_count", 32'(n_rd - s), 32'd10);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // FIFO drains before the burst budget is used up.
    for (int i = 0; i < 3; i++) push(2'd3, 8'hC0 + 8'(i));
    s = n_rd;
    preload(8'hC0, 3);
    wait_drain("drain");
    check("drain_rd_count", 32'(n_rd - s), 32'd3);
    check("drain_grant_idle", 32'(bus.grant), 32'd0);

    // Reset while waiting for the UART with a second command byte held.
    push(2'd1, 8'h77);
    base = n_start;
    strobe(1'b1, 8'h77, 1'b0, 8'h00);
    wait_starts(base + 1);
    tick(3);
    strobe(1'b1, 8'h78, 1'b0, 8'h00);
    tick(1);
    Reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick(3);
    Reset_n = 1'b1;
    base = n_start;
    tick(40);
    check("post_reset_no_tx", 32'(n_start), 32'(base));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
